// File: rtl/alu_seq_if.sv
// Operand/control request and result/flag response bundle for alu_seq.
interface alu_seq_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       control;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             brk;

  modport master (
    output in_valid, control, a, b,
    input  in_ready, out_valid, result, zero, overflow, hi, lo, brk
  );

  modport slave (
    input  in_valid, control, a, b,
    output in_ready, out_valid, result, zero, overflow, hi, lo, brk
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential MIPS ALU: single-cycle ops registered on accept, iterative
// shift-add MULT/MULTU into HI/LO, and a sticky BREAK halt.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input logic    clk,
  input logic    rst_n,
  alu_seq_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HALT} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   result_q, hi_q, lo_q;
  logic               zero_q, ovf_q, brk_q, out_valid_q;
  logic [WIDTH-1:0]   alu_res, sum, diff, mag_a, mag_b, mplier;
  logic               alu_ovf, signed_op, neg;
  logic [2*WIDTH-1:0] mcand, prod, prod_add, prod_fin;
  logic [CW-1:0]      cnt;
  logic               accept, is_mul, is_brk, mul_last;

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.brk       = brk_q;

  always_comb begin
    sum     = bus.a + bus.b;
    diff    = bus.a - bus.b;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.control)
      4'b0000: alu_res = bus.a & bus.b;
      4'b0001: alu_res = bus.a | bus.b;
      4'b0010: begin
        alu_res = sum;
        alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'b0011: alu_res = bus.a ^ bus.b;
      4'b0100: alu_res = sum;
      4'b0101: alu_res = diff;
      4'b0110: begin
        alu_res = diff;
        alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      4'b1011: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      4'b1010: alu_res = WIDTH'({bus.b[15:0], 16'h0000});
      4'b1100,
      4'b1101: alu_res = sum;
      default: alu_res = '0;
    endcase
  end

  // MULT works on magnitudes; the sign is reapplied to the full 2W product.
  always_comb begin
    signed_op = ~bus.control[0];
    mag_a     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    prod_add  = mplier[0] ? (prod + mcand) : prod;
    prod_fin  = neg ? -prod_add : prod_add;
  end

  always_comb begin
    accept     = bus.in_valid && (state == S_IDLE);
    is_mul     = (bus.control[3:1] == 3'b100);
    is_brk     = (bus.control == 4'b1111);
    mul_last   = (cnt == CW'(WIDTH-1));
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept && is_mul)      state_next = S_MUL;
        else if (accept && is_brk) state_next = S_HALT;
      end
      S_MUL:   if (mul_last) state_next = S_IDLE;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      brk_q       <= 1'b0;
      out_valid_q <= 1'b0;
      mcand       <= '0;
      mplier      <= '0;
      prod        <= '0;
      cnt         <= '0;
      neg         <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (accept && !is_mul) begin
        result_q    <= alu_res;
        zero_q      <= (alu_res == '0);
        ovf_q       <= alu_ovf;
        out_valid_q <= 1'b1;
        if (is_brk) brk_q <= 1'b1;
      end
      if (accept && is_mul) begin
        mcand  <= {{WIDTH{1'b0}}, mag_a};
        mplier <= mag_b;
        prod   <= '0;
        cnt    <= '0;
        neg    <= signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      end
      if (state == S_MUL) begin
        prod   <= prod_add;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (mul_last) begin
          hi_q        <= prod_fin[2*WIDTH-1:WIDTH];
          lo_q        <= prod_fin[WIDTH-1:0];
          result_q    <= prod_fin[WIDTH-1:0];
          zero_q      <= (prod_fin[WIDTH-1:0] == '0);
          ovf_q       <= 1'b0;
          out_valid_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: single-cycle ops, multiply timing/results,
// mid-multiply reset and BREAK halt.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(32)) bus ();
  alu_seq #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic op1(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] res, input logic z,
                     input logic ovf);
    bus.in_valid = 1'b1;
    bus.control  = ctrl;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check({tag, ".valid"}, bus.out_valid, 1);
    check({tag, ".result"}, bus.result, res);
    check({tag, ".zero"}, bus.zero, z);
    check({tag, ".ovf"}, bus.overflow, ovf);
  endtask

  task automatic mul(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int cyc;
    bus.in_valid = 1'b1;
    bus.control  = ctrl;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".latency"}, cyc, 32);
    check({tag, ".hi"}, bus.hi, ehi);
    check({tag, ".lo"}, bus.lo, elo);
    check({tag, ".result"}, bus.result, elo);
    check({tag, ".ovf"}, bus.overflow, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] hi_before;
    int seen;

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.control  = 4'h0;
    bus.a        = '0;
    bus.b        = '0;
    #12;
    check("rst.in_ready", bus.in_ready, 1);
    check("rst.out_valid", bus.out_valid, 0);
    check("rst.result", bus.result, 0);
    check("rst.zero", bus.zero, 0);
    check("rst.ovf", bus.overflow, 0);
    check("rst.hi", bus.hi, 0);
    check("rst.lo", bus.lo, 0);
    check("rst.brk", bus.brk, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    op1("add",  4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 1);
    op1("addu", 4'b0100, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 0);
    op1("sub",  4'b0110, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 0, 1);
    op1("slt",  4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, 0);
    op1("sltu", 4'b1011, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0);
    op1("lui",  4'b1010, 32'h0, 32'h0000_1234, 32'h1234_0000, 0, 0);
    op1("subu", 4'b0101, 32'h5, 32'h5, 32'h0, 1, 0);
    op1("sb",   4'b1100, 32'h100, 32'h4, 32'h104, 0, 0);
    op1("c1110", 4'b1110, 32'h1234, 32'h5678, 32'h0, 1, 0);
    check("single.hi_untouched", bus.hi, 0);

    // Detailed MULT timing: in_valid stays high (with ADD) during MUL and must be ignored.
    bus.in_valid = 1'b1;
    bus.control  = 4'b1000;
    bus.a        = 32'hFFFF_FFFD;
    bus.b        = 32'h5;
    @(posedge clk); #1;
    bus.control  = 4'b0010;
    bus.a        = 32'h1;
    bus.b        = 32'h1;
    hi_before    = bus.hi;
    for (int k = 1; k <= 31; k++) begin
      @(posedge clk); #1;
      check("mult.in_ready_low", bus.in_ready, 0);
      check("mult.no_valid", bus.out_valid, 0);
      if (k == 16) check("mult.hi_hidden", bus.hi, hi_before);
      if (k == 31) bus.in_valid = 1'b0;
    end
    @(posedge clk); #1;
    check("mult.valid", bus.out_valid, 1);
    check("mult.in_ready", bus.in_ready, 1);
    check("mult.hi", bus.hi, 32'hFFFF_FFFF);
    check("mult.lo", bus.lo, 32'hFFFF_FFF1);
    check("mult.result", bus.result, 32'hFFFF_FFF1);
    check("mult.zero", bus.zero, 0);
    @(posedge clk); #1;
    check("mult.single_pulse", bus.out_valid, 0);

    mul("multu", 4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    mul("mult_min", 4'b1000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    check("mult_min.zero", bus.zero, 1);

    // Back-to-back single-cycle ops.
    bus.in_valid = 1'b1;
    bus.control  = 4'b0000;
    bus.a        = 32'hF0F0_1234;
    bus.b        = 32'h0FF0_FF00;
    @(posedge clk); #1;
    check("b2b.and.valid", bus.out_valid, 1);
    check("b2b.and", bus.result, 32'h00F0_1200);
    bus.control = 4'b0001;
    @(posedge clk); #1;
    check("b2b.or.valid", bus.out_valid, 1);
    check("b2b.or", bus.result, 32'hFFF0_FF34);
    bus.control = 4'b0011;
    @(posedge clk); #1;
    check("b2b.xor.valid", bus.out_valid, 1);
    check("b2b.xor", bus.result, 32'hFF00_ED34);
    bus.in_valid = 1'b0;
    op1("addu2", 4'b0100, 32'h10, 32'h20, 32'h30, 0, 0);
    check("addu2.hi_kept", bus.hi, 32'h4000_0000);
    check("addu2.lo_kept", bus.lo, 32'h0);

    // Reset in the middle of a multiply.
    bus.in_valid = 1'b1;
    bus.control  = 4'b1000;
    bus.a        = 32'h7;
    bus.b        = 32'h9;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst.in_ready", bus.in_ready, 1);
    check("mrst.out_valid", bus.out_valid, 0);
    check("mrst.result", bus.result, 0);
    check("mrst.zero", bus.zero, 0);
    check("mrst.ovf", bus.overflow, 0);
    check("mrst.hi", bus.hi, 0);
    check("mrst.lo", bus.lo, 0);
    check("mrst.brk", bus.brk, 0);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("mrst.no_output", seen, 0);

    // BREAK halts the unit.
    op1("brk", 4'b1111, 32'h5, 32'h6, 32'h0, 1, 0);
    check("brk.flag", bus.brk, 1);
    check("brk.in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    bus.control  = 4'b0010;
    bus.a        = 32'h3;
    bus.b        = 32'h4;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    bus.in_valid = 1'b0;
    check("brk.no_output", seen, 0);
    check("brk.in_ready_low", bus.in_ready, 0);
    check("brk.sticky", bus.brk, 1);
    check("brk.result_held", bus.result, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
